// File: rtl/mandelbrot_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mandelbrot_pio_pkg
//  Brief    : Shared register map and edge-type encodings for the Mandelbrot
//             Avalon-MM PIO blocks on the lightweight HPS-to-FPGA bridge.
//  Revision : 1.0  initial release
// ============================================================================
package mandelbrot_pio_pkg;

    // Word addresses of the input PIO register map
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Edge-capture selection values for the EDGE_TYPE parameter
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage : mandelbrot_pio_pkg
`default_nettype wire

// File: rtl/bus_sync.sv
`default_nettype none
// ============================================================================
//  Module   : bus_sync
//  Brief    : Multi-stage flip-flop synchroniser for a bus of independent
//             asynchronous level signals. Async active-low reset clears every
//             stage, so a line held high through reset shows up as a 0->1 step.
//  Revision : 1.0  initial release
// ============================================================================
module bus_sync #(
    parameter int WIDTH       = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    // Shift the async bus through the flop chain; stage 0 is the metastable one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign sync_out = stage[SYNC_STAGES-1];

endmodule : bus_sync
`default_nettype wire

// File: rtl/mandelbrot_status_pio_in.sv
`default_nettype none
// ============================================================================
//  Module   : mandelbrot_status_pio_in
//  Brief    : Avalon-MM slave input PIO. Synchronises the engine status bus,
//             captures per-bit edges into a sticky W1C register and raises a
//             maskable level IRQ. Read latency is one clock.
//  Revision : 1.0  initial release
// ============================================================================
module mandelbrot_status_pio_in
    import mandelbrot_pio_pkg::*;
#(
    parameter int               WIDTH        = 27,
    parameter int               SYNC_STAGES  = 2,
    parameter int               EDGE_TYPE    = 0,
    parameter logic [WIDTH-1:0] IRQ_MASK_RST = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] edge_detect;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_clear;
    logic [WIDTH-1:0] irq_mask;
    logic [31:0]      read_mux;
    logic             rd_en;
    logic             wr_en;

    assign rd_en = chipselect & ~read_n;
    assign wr_en = chipselect & ~write_n;

    bus_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (in_port),
        .sync_out (sync_out)
    );

    // One-cycle delayed copy of the synchronised bus for edge comparison
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_d <= '0;
        end else begin
            sync_d <= sync_out;
        end
    end

    // Edge polarity is fixed at elaboration time
    if (EDGE_TYPE == EDGE_RISING) begin : g_edge_rising
        assign edge_detect = sync_out & ~sync_d;
    end else if (EDGE_TYPE == EDGE_FALLING) begin : g_edge_falling
        assign edge_detect = ~sync_out & sync_d;
    end else begin : g_edge_any
        assign edge_detect = sync_out ^ sync_d;
    end

    // Write-1-to-clear bits; only meaningful on a write to the edge register
    assign edge_clear = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // Sticky edge capture; a new edge overrides a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clear) | edge_detect;
        end
    end

    // Interrupt mask is replaced whole on a write to its address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= IRQ_MASK_RST;
        end else if (wr_en && address == ADDR_MASK) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Read mux, zero-extended to the 32-bit bus; address 1 reads as zero
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA: read_mux[WIDTH-1:0] = sync_out;
            ADDR_MASK: read_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: read_mux[WIDTH-1:0] = edge_capture;
            default:   read_mux = '0;
        endcase
    end

    // Registered read data, held between read strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= read_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

    // Write data above WIDTH has no destination
    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_wdata_bits;
        assign unused_wdata_bits = ^writedata[31:WIDTH];
    end

endmodule : mandelbrot_status_pio_in
`default_nettype wire

// File: tb/tb_mandelbrot_status_pio_in.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mandelbrot_status_pio_in
//  Brief    : Self-checking bench for the status input PIO. Three instances
//             share the bus and in_port: rising (default), falling and any-edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mandelbrot_status_pio_in;

    localparam int W = 27;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          read_n = 1'b1;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '0;

    logic [31:0]   rd_rise, rd_fall, rd_any;
    logic          irq_rise, irq_fall, irq_any;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb [$];

    always #5 clk = ~clk;

    mandelbrot_status_pio_in #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MASK_RST('0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd_rise), .in_port(in_port), .irq(irq_rise));

    mandelbrot_status_pio_in #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_MASK_RST('0)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd_fall), .in_port(in_port), .irq(irq_fall));

    mandelbrot_status_pio_in #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_MASK_RST('0)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd_any), .in_port(in_port), .irq(irq_any));

    // Advance one clock; inputs are always changed 1ns after the rising edge
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One read strobe; returns readdata of the selected instance after latency 1
    task automatic do_read(input int which, input logic [1:0] addr, output logic [31:0] got);
        address    = addr;
        chipselect = 1'b1;
        read_n     = 1'b0;
        cyc(1);
        chipselect = 1'b0;
        read_n     = 1'b1;
        case (which)
            1:       got = rd_fall;
            2:       got = rd_any;
            default: got = rd_rise;
        endcase
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Read and compare against the oldest scoreboard entry
    task automatic read_check(input int which, input logic [1:0] addr, input string name);
        logic [31:0] got, exp_v;
        do_read(which, addr, got);
        exp_v = sb.pop_front();
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp_v);
        end
    endtask

    task automatic test_reset();
        in_port = 27'h7FFFFFF;
        reset_n = 1'b0;
        cyc(3);
        total++;
        if (rd_rise !== 32'h0) begin bad++; $display("FAIL reset_readdata: got %h expected %h", rd_rise, 32'h0); end
        total++;
        if (irq_rise !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq_rise); end
        reset_n = 1'b1;
        // edge1 samples read addr2, edge3 first capture, edge4 read sees it
        sb.push_back(32'h0);          read_check(0, 2'd2, "reset_mask");
        sb.push_back(32'h0);          read_check(0, 2'd3, "capture_edge2");
        sb.push_back(32'h0);          read_check(0, 2'd3, "capture_edge3_pre");
        sb.push_back(32'h07FFFFFF);   read_check(0, 2'd3, "capture_after_release");
    endtask

    task automatic test_data_path();
        in_port = 27'h0123456;
        sb.push_back(32'h07FFFFFF);   read_check(0, 2'd0, "data_edge1_old");
        sb.push_back(32'h07FFFFFF);   read_check(0, 2'd0, "data_edge2_old");
        sb.push_back(32'h00123456);   read_check(0, 2'd0, "data_edge3_new");
        sb.push_back(32'h0);          read_check(0, 2'd1, "addr1_zero");
        total++;
        if (rd_rise !== 32'h0) begin bad++; $display("FAIL readdata_hold: got %h expected %h", rd_rise, 32'h0); end
    endtask

    task automatic test_irq();
        do_write(2'd2, 32'hFFFF_FFF1 & 32'h1);
        in_port = '0;
        cyc(4);
        do_write(2'd3, 32'hFFFFFFFF);
        total++;
        if (irq_rise !== 1'b0) begin bad++; $display("FAIL irq_cleared: got %b expected 0", irq_rise); end
        in_port = 27'h1;
        cyc(2);
        total++;
        if (irq_rise !== 1'b0) begin bad++; $display("FAIL irq_early: got %b expected 0", irq_rise); end
        cyc(1);
        total++;
        if (irq_rise !== 1'b1) begin bad++; $display("FAIL irq_n3: got %b expected 1", irq_rise); end
        do_write(2'd3, 32'h1);
        total++;
        if (irq_rise !== 1'b0) begin bad++; $display("FAIL irq_w1c: got %b expected 0", irq_rise); end
        in_port = 27'h21;
        cyc(4);
        total++;
        if (irq_rise !== 1'b0) begin bad++; $display("FAIL irq_masked_bit5: got %b expected 0", irq_rise); end
        sb.push_back(32'h20);         read_check(0, 2'd3, "capture_bit5");
        sb.push_back(32'h20);         read_check(0, 2'd3, "capture_read_no_clear");
    endtask

    task automatic test_collision();
        in_port = 27'h20;
        cyc(4);
        do_write(2'd3, 32'hFFFFFFFF);
        in_port = 27'h21;
        cyc(2);
        // the W1C write lands on the same edge the new capture does
        do_write(2'd3, 32'h1);
        total++;
        if (irq_rise !== 1'b1) begin bad++; $display("FAIL collision_irq: got %b expected 1", irq_rise); end
        sb.push_back(32'h1);          read_check(0, 2'd3, "collision_capture");
    endtask

    task automatic test_edge_types();
        do_write(2'd3, 32'hFFFFFFFF);
        in_port = 27'h29;
        cyc(4);
        sb.push_back(32'h0);          read_check(1, 2'd3, "falling_ignores_rise");
        sb.push_back(32'h8);          read_check(2, 2'd3, "any_sees_rise");
        do_write(2'd3, 32'hFFFFFFFF);
        in_port = 27'h21;
        cyc(4);
        sb.push_back(32'h8);          read_check(2, 2'd3, "any_sees_fall");
        sb.push_back(32'h8);          read_check(1, 2'd3, "falling_sees_fall");
        sb.push_back(32'h0);          read_check(0, 2'd3, "rising_ignores_fall");
    endtask

    task automatic test_back_to_back_rw();
        logic [31:0] got, exp_v;
        do_write(2'd2, 32'hFF);
        // simultaneous read and write of the mask returns the old value
        sb.push_back(32'hFF);
        address    = 2'd2;
        writedata  = 32'hFFFF_FF0F;
        chipselect = 1'b1;
        read_n     = 1'b0;
        write_n    = 1'b0;
        cyc(1);
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        got   = rd_rise;
        exp_v = sb.pop_front();
        total++;
        if (got !== exp_v) begin bad++; $display("FAIL rw_same_cycle: got %h expected %h", got, exp_v); end
        sb.push_back(32'h07FFFF0F);   read_check(0, 2'd2, "mask_upper_ignored");
    endtask

    task automatic test_async_reset();
        do_write(2'd2, 32'hFF);
        in_port = '0;
        cyc(4);
        do_write(2'd3, 32'hFFFFFFFF);
        in_port = 27'h55;
        cyc(4);
        total++;
        if (irq_rise !== 1'b1) begin bad++; $display("FAIL pre_reset_irq: got %b expected 1", irq_rise); end
        sb.push_back(32'h55);         read_check(0, 2'd3, "pre_reset_capture");
        in_port = '0;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (irq_rise !== 1'b0) begin bad++; $display("FAIL async_reset_irq: got %b expected 0", irq_rise); end
        total++;
        if (rd_rise !== 32'h0) begin bad++; $display("FAIL async_reset_readdata: got %h expected %h", rd_rise, 32'h0); end
        cyc(2);
        reset_n = 1'b1;
        sb.push_back(32'h0);          read_check(0, 2'd3, "post_reset_capture");
        sb.push_back(32'h0);          read_check(0, 2'd2, "post_reset_mask");
    endtask

    initial begin
        cyc(1);
        test_reset();
        test_data_path();
        test_irq();
        test_collision();
        test_edge_types();
        test_back_to_back_rw();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mandelbrot_status_pio_in
`default_nettype wire
